// File: rtl/uart_txd_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned DATA_BITS = 8;

  // Width of a counter spanning 0..clks-1, never narrower than one bit.
  function automatic int unsigned baud_cnt_w(input int unsigned clks);
    return (clks <= 2) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/uart_txd_if.sv
// Byte handshake between a byte source (master) and the transmitter (slave).
interface uart_txd_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data_in;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output data_in, output tx_valid, input tx_ready);
  modport slave  (input data_in, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_txd_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, bit_end on the last count.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic bit_end
);

  localparam int unsigned     CW   = baud_cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign bit_end = en && (cnt == LAST);

endmodule

// File: rtl/uart_txd.sv
// 8N1 UART transmitter with valid/ready byte intake.
// Optional hex segment display of the last accepted byte: define UART_TXD_SEG_EN.
module uart_txd
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter int unsigned BAUD         = 9600,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_txd_if.slave  tx_if,
  output logic       tx_done,
  output logic       txd
`ifdef UART_TXD_SEG_EN
  ,
  output logic [6:0] seg_hi,
  output logic [6:0] seg_lo
`endif
);

  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 txd_q, txd_d;
  logic                 ready, accept, bit_end;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .en      (state_q != IDLE),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    ready     = 1'b0;
    tx_done   = 1'b0;
    case (state_q)
      IDLE:  ready = 1'b1;
      START: if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
            state_d   = STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          ready   = 1'b1;
          tx_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Acceptance overrides the STOP->IDLE step so back-to-back frames have no gap.
    accept = ready && tx_if.tx_valid;
    if (accept) begin
      state_d   = START;
      shreg_d   = tx_if.data_in;
      bit_cnt_d = '0;
    end
    // txd is registered from the next state so the line never glitches.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shreg_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
    end
  end

  assign txd            = txd_q;
  assign tx_if.tx_ready = ready;

`ifdef UART_TXD_SEG_EN
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_hi <= 7'b1000000;
      seg_lo <= 7'b1000000;
    end else if (accept) begin
      seg_hi <= hex7(tx_if.data_in[7:4]);
      seg_lo <= hex7(tx_if.data_in[3:0]);
    end
  end
`endif

endmodule

// File: tb/tb_uart_txd.sv
// Directed bench for uart_txd with a frame-decoding monitor and expected-byte scoreboard.
module tb_uart_txd;
  import uart_pkg::*;

  localparam int CPB = 4;
  localparam int FRAME = 10 * CPB;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_done, txd;
`ifdef UART_TXD_SEG_EN
  logic [6:0] seg_hi, seg_lo;
`endif

  uart_txd_if u_if ();

  uart_txd #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_if   (u_if),
    .tx_done (tx_done),
    .txd     (txd)
`ifdef UART_TXD_SEG_EN
    ,
    .seg_hi  (seg_hi),
    .seg_lo  (seg_lo)
`endif
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  exp_t q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: decodes each frame cycle-by-cycle and checks it against the scoreboard.
  logic       mon_busy = 1'b0;
  int         mon_cnt = 0;
  logic [9:0] mon_bits;
  exp_t       mon_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_busy = 1'b0;
    end else begin
      if (tx_done === 1'b1) done_cnt++;
      if (!mon_busy && txd === 1'b0) begin
        mon_busy = 1'b1;
        mon_cnt  = 0;
        if (q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
          mon_exp.data = 8'h00;
          mon_exp.cyc  = cyc - 1;
        end else begin
          mon_exp = q.pop_front();
        end
        chk("start_latency", cyc, mon_exp.cyc + 1);
      end
      if (mon_busy) begin
        if (mon_cnt % CPB == 0) mon_bits[mon_cnt / CPB] = txd;
        else chk("bit_hold", txd, mon_bits[mon_cnt / CPB]);
        chk("ready_in_frame", u_if.tx_ready, mon_cnt == FRAME - 1);
        chk("done_in_frame", tx_done, mon_cnt == FRAME - 1);
        if (mon_cnt == FRAME - 1) begin
          chk("stop_bit", mon_bits[9], 1);
          chk("data_byte", mon_bits[8:1], mon_exp.data);
          mon_busy = 1'b0;
        end
        mon_cnt++;
      end else begin
        chk("idle_done", tx_done, 0);
        chk("idle_ready", u_if.tx_ready, 1);
      end
    end
  end

  // Offers a byte and returns once it is accepted; acc_cyc is the acceptance cycle.
  task automatic send(input logic [7:0] b, output int acc_cyc);
    bit ok = 0;
    u_if.data_in  = b;
    u_if.tx_valid = 1'b1;
    acc_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (u_if.tx_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    acc_cyc = cyc;
    q.push_back('{data: b, cyc: cyc});
    @(posedge clk);
    #1;
    u_if.tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !mon_busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int c, c2, d0;
    u_if.data_in  = 8'h00;
    u_if.tx_valid = 1'b0;
    #12;
    chk("reset_txd", txd, 1);
    chk("reset_ready", u_if.tx_ready, 1);
    chk("reset_done", tx_done, 0);
`ifdef UART_TXD_SEG_EN
    chk("reset_seg_hi", seg_hi, 7'b1000000);
    chk("reset_seg_lo", seg_lo, 7'b1000000);
`endif
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single byte 0x55
    d0 = done_cnt;
    send(8'h55, c);
    wait_idle();
    chk("single_done_count", done_cnt - d0, 1);

    // Back-to-back 0xA5 then 0x3C with tx_valid held
    d0 = done_cnt;
    send(8'hA5, c);
`ifdef UART_TXD_SEG_EN
    chk("seg_hi_A5", seg_hi, 7'b0001000);
    chk("seg_lo_A5", seg_lo, 7'b0010010);
`endif
    send(8'h3C, c2);
    chk("b2b_spacing", c2 - c, FRAME);
`ifdef UART_TXD_SEG_EN
    chk("seg_hi_3C", seg_hi, 7'b0110000);
    chk("seg_lo_3C", seg_lo, 7'b1000110);
`endif
    wait_idle();
    chk("b2b_done_count", done_cnt - d0, 2);

    // Offer while busy is ignored
    d0 = done_cnt;
    send(8'h00, c);
    repeat (9) @(posedge clk);
    #1;
    u_if.data_in  = 8'hFF;
    u_if.tx_valid = 1'b1;
    @(negedge clk);
    chk("busy_ready_low", u_if.tx_ready, 0);
    @(posedge clk);
    #1;
    u_if.tx_valid = 1'b0;
    wait_idle();
    repeat (FRAME + 5) @(posedge clk);
    #1;
    chk("ignore_done_count", done_cnt - d0, 1);
    chk("ignore_no_frame", mon_busy, 0);
`ifdef UART_TXD_SEG_EN
    chk("seg_hi_held", seg_hi, 7'b1000000);
    chk("seg_lo_held", seg_lo, 7'b1000000);
`endif

    // data_in churns after acceptance of 0x81
    send(8'h81, c);
    for (int i = 0; i < FRAME + 4; i++) begin
      u_if.data_in = 8'($urandom);
      @(posedge clk);
      #1;
    end
    wait_idle();

    // Asynchronous reset during DATA bit 3 of 0xF0, then a clean 0x0F frame
    send(8'hF0, c);
    repeat (c + 1 + CPB + 3 * CPB + 1 - cyc) @(negedge clk);
    #2;
    chk("pre_reset_txd", txd, 0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_txd", txd, 1);
    chk("async_reset_ready", u_if.tx_ready, 1);
    chk("async_reset_done", tx_done, 0);
    q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    d0 = done_cnt;
    send(8'h0F, c);
    wait_idle();
    chk("post_reset_done_count", done_cnt - d0, 1);
    chk("scoreboard_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_txd.md
Name: uart_txd

Overview:
- UART serial transmitter. It is the transmit-side counterpart of the existing UART receive path and its hex display.
- Accepts one byte over a valid/ready handshake and serialises it as 8N1: 1 start bit, 8 data bits LSB first, 1 stop bit, with txd idle-high.
- Sits between the board's byte source (switches or a loopback from the receiver) and the TXD pin.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD: clocks per bit period. Must be at least 2; the bench overrides it to 4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  8  byte to send; sampled only at acceptance.
- tx_valid  input  1  a byte is offered on data_in.
- tx_ready  output  1  transmitter can accept a byte this cycle.
- tx_done  output  1  one-cycle pulse when a frame's stop bit completes.
- txd  output  1  serial line, idle high.
- seg_hi  output  7  active-low segments, upper nibble of the last accepted byte. Present only with UART_TXD_SEG_EN.
- seg_lo  output  7  active-low segments, lower nibble of the last accepted byte. Present only with UART_TXD_SEG_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: txd=1, tx_ready=1, tx_done=0, state=IDLE, bit counter=0, baud counter=0.
- Reset mid-frame: txd returns to 1 immediately (asynchronously) and the frame is abandoned. There is no partial-frame resumption.
- Handshake: a byte is accepted in cycle N when tx_valid=1 and tx_ready=1. data_in is captured into a shift register in that cycle.
  - tx_ready is low from N+1 until the end of the frame.
  - tx_valid while tx_ready=0 is ignored and not queued. The source must hold tx_valid.
  - Changes on data_in after acceptance do not affect the frame in flight.
- State machine: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: txd=1, tx_ready=1. On acceptance go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, beginning at N+1.
  - DATA: txd = shift register bit 0, each bit held CLKS_PER_BIT cycles, then shift right. Bit counter runs 0..7; after bit 7 expires go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles.
- End of frame: in the last cycle of STOP, tx_ready=1 and tx_done=1 together (combinationally from the final baud count).
  - If tx_valid=1 in that cycle, the next byte is accepted and START begins the following cycle. Back-to-back frames therefore have no idle gap and the stop bit is exactly CLKS_PER_BIT wide.
  - Otherwise return to IDLE.
- Timing: a frame is exactly 10*CLKS_PER_BIT cycles from N+1. The baud counter is clog2(CLKS_PER_BIT) bits wide and counts 0..CLKS_PER_BIT-1. It is reset to 0 at acceptance and on every bit boundary.
- txd is registered and glitch-free.

Optional Feature:
- Macro: UART_TXD_SEG_EN.
- Defined:
  - seg_hi and seg_lo exist and are registered at acceptance from data_in[7:4] and data_in[3:0].
  - Encoding is the team's standard active-low hex map: 0=1000000, 3=0110000, 5=0010010, A=0001000, C=1000110, F=0001110.
  - Reset value of both is 1000000 (shows "0").
- Undefined: both ports and their registers are absent. Serial behaviour is identical either way.

Decomposition:
- Package uart_pkg holds:
  - state encoding localparams: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - DATA_BITS=8;
  - a constant function for the baud counter width.
- One natural sub-module, uart_baud_tick: a counter with clear and enable that emits bit_end on count CLKS_PER_BIT-1.
- The FSM and shift register stay in uart_txd.
- The optional segment encoding is an inline case statement, not a new module.

Test Plan:
- Single byte: CLKS_PER_BIT=4, send 0x55 -> txd=0,1,0,1,0,1,0,1,0,1 with each bit 4 cycles; tx_done pulses once at cycle 40 after acceptance; tx_ready high in that cycle.
- Back-to-back: tx_valid held with 0xA5 then 0x3C -> second START immediately follows the 4-cycle stop bit, no idle gap; two tx_done pulses 40 cycles apart; decoded bytes match.
- Ignore while busy: pulse tx_valid with 0xFF at cycle 10 of a 0x00 frame, while tx_ready=0 -> frame stays 0x00; no second frame; tx_done pulses once.
- Data stability: change data_in every cycle after accepting 0x81 -> serial bits still 1,0,0,0,0,0,0,1 (LSB first).
- Reset mid-frame: assert rst_n=0 in DATA bit 3 -> txd=1 and tx_ready=1 without waiting for clk. After release, a new 0x0F frame transmits correctly from START.
- UART_TXD_SEG_EN defined:
  - after reset, seg_hi=seg_lo=1000000;
  - accept 0x3C -> seg_hi=0110000, seg_lo=1000110 from the cycle after acceptance, held until the next acceptance.
